pattern_loader: RTL

PATTERN_LOADER -- requirements
Module: pattern_loader

---
 rtl/pattern_loader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pattern_loader.sv
`default_nettype none
// ==========================================================================
// pattern_loader : serialises a parallel pattern into a decoder's program
//                  shift register, then raises armed once it is complete.
// rev 1.0
// ==========================================================================
module pattern_loader #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] pat_in,
  input  logic             pat_valid,
  output logic             pat_ready,
  output logic             prgm,
  output logic             prgm_en,
  output logic             busy,
  output logic             done,
  output logic             armed
);

  localparam int              c_cw    = $clog2(WIDTH) + 1;
  localparam logic [c_cw-1:0] c_last  = c_cw'(WIDTH - 1);
  localparam logic [c_cw-1:0] c_one   = c_cw'(1);
  localparam logic [0:0]      c_idle  = 1'b0;
  localparam logic [0:0]      c_shift = 1'b1;

  logic [0:0]       r_state, w_state_nxt;
  logic [c_cw-1:0]  r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shadow, w_shadow_nxt;
  logic             r_prgm, w_prgm_nxt;
  logic             r_prgm_en, w_prgm_en_nxt;
  logic             r_done, w_done_nxt;
  logic             r_armed, w_armed_nxt;
  logic [WIDTH-1:0] w_ordered;
  logic             w_accept;
  logic             w_last;

  // Reorder the pattern so bit 0 of the shadow is always the next bit out.
  if (MSB_FIRST != 0) begin : g_msb_first
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign w_ordered[i] = pat_in[WIDTH-1-i];
    end
  end else begin : g_lsb_first
    assign w_ordered = pat_in;
  end

  assign w_accept = pat_valid && (r_state == c_idle);
  assign w_last   = (r_cnt == c_last);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= c_idle;
      r_cnt     <= '0;
      r_shadow  <= '0;
      r_prgm    <= 1'b0;
      r_prgm_en <= 1'b0;
      r_done    <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shadow  <= w_shadow_nxt;
      r_prgm    <= w_prgm_nxt;
      r_prgm_en <= w_prgm_en_nxt;
      r_done    <= w_done_nxt;
      r_armed   <= w_armed_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (w_accept) w_state_nxt = c_shift;
      c_shift: if (w_last)   w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  // Outputs are computed one cycle ahead so every port leaves a flop.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_shadow_nxt  = r_shadow;
    w_prgm_nxt    = 1'b0;
    w_prgm_en_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    w_armed_nxt   = r_armed;
    case (r_state)
      c_idle: begin
        if (w_accept) begin
          w_cnt_nxt     = '0;
          w_shadow_nxt  = w_ordered >> 1;
          w_prgm_nxt    = w_ordered[0];
          w_prgm_en_nxt = 1'b1;
          w_armed_nxt   = 1'b0;
        end
      end
      c_shift: begin
        if (w_last) begin
          w_done_nxt  = 1'b1;
          w_armed_nxt = 1'b1;
        end else begin
          w_cnt_nxt     = r_cnt + c_one;
          w_shadow_nxt  = r_shadow >> 1;
          w_prgm_nxt    = r_shadow[0];
          w_prgm_en_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pat_ready = (r_state == c_idle);
  assign busy      = (r_state == c_shift);
  assign prgm      = r_prgm;
  assign prgm_en   = r_prgm_en;
  assign done      = r_done;
  assign armed     = r_armed;

endmodule
`default_nettype wire
